mrd_bank_sched: RTL and testbench

- N-bank generalisation of the Mixed Radix DFT ping-pong top control.
- Schedules NUM_BANKS memory banks (mrd_mem_top instances) round-robin: one bank sinks, others compute or source. Packets complete and leave in arrival order.
- Latches per-bank DFT size and issues calc-start pulses.
- Drives the input/output switch selects and flags illegal handshakes.
- Sits between the sink/source mux fabric and the per-bank memory tops.

---
 rtl/mrd_sched_pkg.sv | 17 +
 rtl/mrd_bank_fsm.sv | 65 ++++++
 rtl/mrd_bank_sched.sv | 75 +++++++
 tb/tb_mrd_bank_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mrd_sched_pkg.sv
// rtl/mrd_sched_pkg.sv - bank state encoding and pointer helper for the bank scheduler
package mrd_sched_pkg;

  typedef enum logic [2:0] {
    BANK_IDLE     = 3'd0,
    BANK_SINK     = 3'd1,
    BANK_CALC     = 3'd2,
    BANK_WAIT_SRC = 3'd3,
    BANK_SRC      = 3'd4
  } bank_state_e;

  // Compare-and-clear wrap so bank counts that are not a power of two behave.
  function automatic int unsigned next_bank(input int unsigned sel, input int unsigned n);
    return (sel + 1 >= n) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/mrd_bank_fsm.sv
// rtl/mrd_bank_fsm.sv - one memory bank's lifecycle FSM, point-count latch and protocol checks
module mrd_bank_fsm
  import mrd_sched_pkg::*;
#(
  parameter int PTS_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_sel_in,
  input  logic             is_sel_out,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [PTS_W-1:0] sink_dftpts,
  input  logic             calc_done,
  input  logic             source_start,
  input  logic             source_end,
  output logic [2:0]       state,
  output logic [PTS_W-1:0] dftpts,
  output logic             calc_start,
  output logic             sink_done,
  output logic             src_done,
  output logic             err
);

  bank_state_e state_q, state_d;
  logic sop_ok, eop_ok, done_ok, start_ok, end_ok;

  assign sop_ok   = sink_sop && is_sel_in && (state_q == BANK_IDLE);
  // A same-cycle sop+eop is a one-sample packet, so eop is legal alongside an accepted sop.
  assign eop_ok   = sink_eop && ((state_q == BANK_SINK) || sop_ok);
  assign done_ok  = calc_done && (state_q == BANK_CALC);
  assign start_ok = source_start && is_sel_out && (state_q == BANK_WAIT_SRC);
  assign end_ok   = source_end && (state_q == BANK_SRC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      BANK_IDLE:     if (sop_ok)   state_d = eop_ok ? BANK_CALC : BANK_SINK;
      BANK_SINK:     if (eop_ok)   state_d = BANK_CALC;
      BANK_CALC:     if (done_ok)  state_d = BANK_WAIT_SRC;
      BANK_WAIT_SRC: if (start_ok) state_d = BANK_SRC;
      BANK_SRC:      if (end_ok)   state_d = BANK_IDLE;
      default:                     state_d = BANK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BANK_IDLE;
      dftpts     <= '0;
      calc_start <= 1'b0;
    end else begin
      state_q    <= state_d;
      calc_start <= eop_ok;
      if (sop_ok) dftpts <= sink_dftpts;
    end
  end

  assign state     = state_q;
  assign sink_done = eop_ok;
  assign src_done  = end_ok;
  assign err       = (sink_sop && !sop_ok) || (sink_eop && !eop_ok) || (calc_done && !done_ok)
                  || (source_start && !start_ok) || (source_end && !end_ok);

endmodule

// File: rtl/mrd_bank_sched.sv
// rtl/mrd_bank_sched.sv - round-robin scheduler for NUM_BANKS mixed-radix DFT memory banks
module mrd_bank_sched
  import mrd_sched_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int PTS_W     = 12,
  parameter int SEL_W     = $clog2(NUM_BANKS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BANKS-1:0]       sink_sop_i,
  input  logic [NUM_BANKS-1:0]       sink_eop_i,
  input  logic [NUM_BANKS*PTS_W-1:0] sink_dftpts_i,
  input  logic [NUM_BANKS-1:0]       calc_done_i,
  input  logic [NUM_BANKS-1:0]       source_start_i,
  input  logic [NUM_BANKS-1:0]       source_end_i,
  output logic [SEL_W-1:0]           sel_in_o,
  output logic [SEL_W-1:0]           sel_out_o,
  output logic                       in_ready_o,
  output logic [NUM_BANKS-1:0]       calc_start_o,
  output logic [NUM_BANKS*3-1:0]     bank_state_o,
  output logic [NUM_BANKS*PTS_W-1:0] dftpts_o,
  output logic                       err_o
);

  logic [SEL_W-1:0]     sel_in_q, sel_out_q;
  logic [NUM_BANKS-1:0] sink_done, src_done, bank_err, bank_idle;
  logic                 err_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mrd_bank_fsm #(.PTS_W(PTS_W)) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .is_sel_in    (sel_in_q == SEL_W'(b)),
      .is_sel_out   (sel_out_q == SEL_W'(b)),
      .sink_sop     (sink_sop_i[b]),
      .sink_eop     (sink_eop_i[b]),
      .sink_dftpts  (sink_dftpts_i[b*PTS_W +: PTS_W]),
      .calc_done    (calc_done_i[b]),
      .source_start (source_start_i[b]),
      .source_end   (source_end_i[b]),
      .state        (bank_state_o[b*3 +: 3]),
      .dftpts       (dftpts_o[b*PTS_W +: PTS_W]),
      .calc_start   (calc_start_o[b]),
      .sink_done    (sink_done[b]),
      .src_done     (src_done[b]),
      .err          (bank_err[b])
    );
    assign bank_idle[b] = (bank_state_o[b*3 +: 3] == BANK_IDLE);
  end

  always_comb begin
    in_ready_o = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (sel_in_q == SEL_W'(b)) in_ready_o = bank_idle[b];
  end

  // Only the bank under each pointer can complete its phase, so an OR is enough to advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_in_q  <= '0;
      sel_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (|sink_done) sel_in_q  <= SEL_W'(next_bank(32'(sel_in_q), NUM_BANKS));
      if (|src_done)  sel_out_q <= SEL_W'(next_bank(32'(sel_out_q), NUM_BANKS));
      err_q <= err_q | (|bank_err);
    end
  end

  assign sel_in_o  = sel_in_q;
  assign sel_out_o = sel_out_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mrd_bank_sched.sv
// tb/tb_mrd_bank_sched.sv - directed and randomized checks of mrd_bank_sched with 2 and 3 banks
module tb_mrd_bank_sched;
  localparam int IDLE = 0, SINK = 1, CALC = 2, WAIT = 3, SRC = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  s2_sop = '0, s2_eop = '0, s2_cd = '0, s2_ss = '0, s2_se = '0;
  logic [23:0] s2_pts = '0;
  logic        s2_sel_in, s2_sel_out, s2_rdy, s2_err;
  logic [1:0]  s2_cs;
  logic [5:0]  s2_st;
  logic [23:0] s2_dp;

  logic [2:0]  s3_sop = '0, s3_eop = '0, s3_cd = '0, s3_ss = '0, s3_se = '0;
  logic [35:0] s3_pts = '0;
  logic [1:0]  s3_sel_in, s3_sel_out;
  logic        s3_rdy, s3_err;
  logic [2:0]  s3_cs;
  logic [8:0]  s3_st;
  logic [35:0] s3_dp;

  mrd_bank_sched #(.NUM_BANKS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sink_sop_i(s2_sop), .sink_eop_i(s2_eop), .sink_dftpts_i(s2_pts),
    .calc_done_i(s2_cd), .source_start_i(s2_ss), .source_end_i(s2_se), .sel_in_o(s2_sel_in),
    .sel_out_o(s2_sel_out), .in_ready_o(s2_rdy), .calc_start_o(s2_cs), .bank_state_o(s2_st),
    .dftpts_o(s2_dp), .err_o(s2_err));

  mrd_bank_sched #(.NUM_BANKS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sink_sop_i(s3_sop), .sink_eop_i(s3_eop), .sink_dftpts_i(s3_pts),
    .calc_done_i(s3_cd), .source_start_i(s3_ss), .source_end_i(s3_se), .sel_in_o(s3_sel_in),
    .sel_out_o(s3_sel_out), .in_ready_o(s3_rdy), .calc_start_o(s3_cs), .bank_state_o(s3_st),
    .dftpts_o(s3_dp), .err_o(s3_err));

  int checks = 0, errors = 0;

  // Reference model: per-DUT bank phases, pointers and sticky error.
  int          st_m[2][3];
  logic [11:0] pts_m[2][3];
  int          sel_in_m[2], sel_out_m[2];
  logic        err_m[2];
  logic [2:0]  cs_m[2];

  function automatic logic [2:0]  a_st(input int d, input int b); return d ? s3_st[b*3 +: 3] : s2_st[b*3 +: 3]; endfunction
  function automatic logic [11:0] a_dp(input int d, input int b); return d ? s3_dp[b*12 +: 12] : s2_dp[b*12 +: 12]; endfunction
  function automatic logic [1:0]  a_sin(input int d);  return d ? s3_sel_in : {1'b0, s2_sel_in}; endfunction
  function automatic logic [1:0]  a_sout(input int d); return d ? s3_sel_out : {1'b0, s2_sel_out}; endfunction
  function automatic logic [2:0]  a_cs(input int d);   return d ? s3_cs : {1'b0, s2_cs}; endfunction
  function automatic logic        a_rdy(input int d);  return d ? s3_rdy : s2_rdy; endfunction
  function automatic logic        a_err(input int d);  return d ? s3_err : s2_err; endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 3; b++) begin st_m[d][b] = IDLE; pts_m[d][b] = '0; end
      sel_in_m[d] = 0; sel_out_m[d] = 0; err_m[d] = 1'b0; cs_m[d] = '0;
    end
  endtask

  task automatic model_step(input int d, input logic [2:0] sop, eop, cd, ss, se, input logic [35:0] pts);
    int nb, s;
    bit take, adv_in, adv_out;
    nb = d ? 3 : 2;
    adv_in = 0; adv_out = 0; cs_m[d] = '0;
    for (int b = 0; b < nb; b++) begin
      s = st_m[d][b];
      take = sop[b] && (b == sel_in_m[d]) && (s == IDLE);
      if ((sop[b] && !take) || (eop[b] && !(take || s == SINK)) || (cd[b] && s != CALC)
          || (ss[b] && !(s == WAIT && b == sel_out_m[d])) || (se[b] && s != SRC)) err_m[d] = 1'b1;
      if (take) begin pts_m[d][b] = pts[b*12 +: 12]; st_m[d][b] = SINK; end
      if (eop[b] && (take || s == SINK)) begin st_m[d][b] = CALC; cs_m[d][b] = 1'b1; adv_in = 1; end
      if (cd[b] && s == CALC) st_m[d][b] = WAIT;
      if (ss[b] && s == WAIT && b == sel_out_m[d]) st_m[d][b] = SRC;
      if (se[b] && s == SRC) begin st_m[d][b] = IDLE; adv_out = 1; end
    end
    if (adv_in)  sel_in_m[d]  = (sel_in_m[d] + 1) % nb;
    if (adv_out) sel_out_m[d] = (sel_out_m[d] + 1) % nb;
  endtask

  task automatic step(input int d, input logic [2:0] sop, eop, cd, ss, se, input logic [35:0] pts);
    if (d == 0) begin
      s2_sop = sop[1:0]; s2_eop = eop[1:0]; s2_cd = cd[1:0]; s2_ss = ss[1:0]; s2_se = se[1:0]; s2_pts = pts[23:0];
    end else begin
      s3_sop = sop; s3_eop = eop; s3_cd = cd; s3_ss = ss; s3_se = se; s3_pts = pts;
    end
    @(posedge clk);
    if (rst_n) model_step(d, sop, eop, cd, ss, se, pts); else model_reset();
    #1;
    s2_sop = '0; s2_eop = '0; s2_cd = '0; s2_ss = '0; s2_se = '0; s2_pts = '0;
    s3_sop = '0; s3_eop = '0; s3_cd = '0; s3_ss = '0; s3_se = '0; s3_pts = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks++; if (a_rdy(d) !== 1'b1)  begin errors++; $display("FAIL reset_rdy d%0d: got %b exp 1", d, a_rdy(d)); end
      checks++; if (a_sin(d) !== 2'd0)  begin errors++; $display("FAIL reset_sel_in d%0d: got %0d exp 0", d, a_sin(d)); end
      checks++; if (a_sout(d) !== 2'd0) begin errors++; $display("FAIL reset_sel_out d%0d: got %0d exp 0", d, a_sout(d)); end
      checks++; if (a_cs(d) !== 3'd0)   begin errors++; $display("FAIL reset_calc_start d%0d: got %b exp 0", d, a_cs(d)); end
      checks++; if (a_err(d) !== 1'b0)  begin errors++; $display("FAIL reset_err d%0d: got %b exp 0", d, a_err(d)); end
      for (int b = 0; b < (d ? 3 : 2); b++) begin
        checks++; if (a_st(d, b) !== 3'd0)  begin errors++; $display("FAIL reset_state d%0d b%0d: got %0d exp 0", d, b, a_st(d, b)); end
        checks++; if (a_dp(d, b) !== 12'd0) begin errors++; $display("FAIL reset_dftpts d%0d b%0d: got %0d exp 0", d, b, a_dp(d, b)); end
      end
    end
  endtask

  task automatic test_one_packet();
    do_reset();
    step(0, 3'b001, 0, 0, 0, 0, 36'd1200);
    checks++; if (a_dp(0, 0) !== 12'd1200) begin errors++; $display("FAIL pkt_dftpts: got %0d exp 1200", a_dp(0, 0)); end
    repeat (1199) step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (a_st(0, 0) !== 3'd1 || a_rdy(0) !== 1'b0) begin errors++; $display("FAIL pkt_sinking: got state %0d rdy %b exp 1 0", a_st(0, 0), a_rdy(0)); end
    step(0, 0, 3'b001, 0, 0, 0, 0);
    checks++; if (a_sin(0) !== 2'd1) begin errors++; $display("FAIL pkt_sel_in: got %0d exp 1", a_sin(0)); end
    checks++; if (a_cs(0) !== 3'b001 || a_st(0, 0) !== 3'd2) begin errors++; $display("FAIL pkt_calc_start: got cs %b state %0d exp 001 2", a_cs(0), a_st(0, 0)); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (a_cs(0) !== 3'b000) begin errors++; $display("FAIL pkt_calc_start_pulse: got %b exp 000", a_cs(0)); end
    step(0, 0, 0, 3'b001, 0, 0, 0);
    step(0, 0, 0, 0, 3'b001, 0, 0);
    checks++; if (a_st(0, 0) !== 3'd4) begin errors++; $display("FAIL pkt_src: got %0d exp 4", a_st(0, 0)); end
    step(0, 0, 0, 0, 0, 3'b001, 0);
    checks++; if (a_st(0, 0) !== 3'd0 || a_sout(0) !== 2'd1 || a_err(0) !== 1'b0) begin
      errors++; $display("FAIL pkt_done: got state %0d sel_out %0d err %b exp 0 1 0", a_st(0, 0), a_sout(0), a_err(0)); end
  endtask

  task automatic test_full();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      step(1, 3'(1 << p), 0, 0, 0, 0, 36'(100 + p) << (12 * p));
      step(1, 0, 3'(1 << p), 0, 0, 0, 0);
    end
    checks++; if (a_rdy(1) !== 1'b0 || a_sin(1) !== 2'd0) begin errors++; $display("FAIL full_ready: got rdy %b sel_in %0d exp 0 0", a_rdy(1), a_sin(1)); end
    step(1, 3'b001, 0, 0, 0, 0, 36'd99);
    checks++; if (a_err(1) !== 1'b1) begin errors++; $display("FAIL full_err: got %b exp 1", a_err(1)); end
    checks++; if (a_st(1, 0) !== 3'd2 || a_dp(1, 0) !== 12'd100) begin
      errors++; $display("FAIL full_unchanged: got state %0d dftpts %0d exp 2 100", a_st(1, 0), a_dp(1, 0)); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    step(1, 3'b001, 3'b001, 0, 0, 0, 36'd7);
    step(1, 3'b010, 3'b010, 0, 0, 0, 36'd8 << 12);
    step(1, 0, 0, 3'b010, 0, 0, 0);
    checks++; if (a_st(1, 1) !== 3'd3 || a_st(1, 0) !== 3'd2) begin errors++; $display("FAIL ooo_wait: got b1 %0d b0 %0d exp 3 2", a_st(1, 1), a_st(1, 0)); end
    step(1, 0, 0, 0, 3'b010, 0, 0);
    checks++; if (a_err(1) !== 1'b1 || a_st(1, 1) !== 3'd3) begin errors++; $display("FAIL ooo_start_err: got err %b state %0d exp 1 3", a_err(1), a_st(1, 1)); end
    step(1, 0, 0, 3'b001, 0, 0, 0);
    step(1, 0, 0, 0, 3'b001, 0, 0);
    step(1, 0, 0, 0, 0, 3'b001, 0);
    step(1, 0, 0, 0, 3'b010, 0, 0);
    checks++; if (a_sout(1) !== 2'd1 || a_st(1, 1) !== 3'd4) begin errors++; $display("FAIL ooo_drain: got sel_out %0d b1 %0d exp 1 4", a_sout(1), a_st(1, 1)); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int b = 0; b < 2; b++) begin
      step(0, 3'(1 << b), 3'(1 << b), 0, 0, 0, 36'd5 << (12 * b));
      step(0, 0, 0, 3'(1 << b), 0, 0, 0);
      step(0, 0, 0, 0, 3'(1 << b), 0, 0);
      if (b == 0) step(0, 0, 0, 0, 0, 3'b001, 0);
    end
    step(0, 3'b001, 0, 0, 0, 0, 36'd9);
    step(0, 0, 3'b001, 0, 0, 3'b010, 0);
    checks++; if (a_st(0, 0) !== 3'd2 || a_st(0, 1) !== 3'd0) begin errors++; $display("FAIL simul_states: got b0 %0d b1 %0d exp 2 0", a_st(0, 0), a_st(0, 1)); end
    checks++; if (a_sin(0) !== 2'd1 || a_sout(0) !== 2'd0 || a_err(0) !== 1'b0) begin
      errors++; $display("FAIL simul_ptrs: got sel_in %0d sel_out %0d err %b exp 1 0 0", a_sin(0), a_sout(0), a_err(0)); end
  endtask

  task automatic test_one_sample();
    do_reset();
    step(0, 3'b001, 3'b001, 0, 0, 0, 36'd12);
    checks++; if (a_st(0, 0) !== 3'd2 || a_dp(0, 0) !== 12'd12) begin errors++; $display("FAIL one_sample: got state %0d dftpts %0d exp 2 12", a_st(0, 0), a_dp(0, 0)); end
    checks++; if (a_cs(0) !== 3'b001 || a_sin(0) !== 2'd1) begin errors++; $display("FAIL one_sample_cs: got cs %b sel_in %0d exp 001 1", a_cs(0), a_sin(0)); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (a_cs(0) !== 3'b000) begin errors++; $display("FAIL one_sample_pulse: got %b exp 000", a_cs(0)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 3'b001, 3'b001, 0, 0, 0, 36'd33);
    step(1, 3'b010, 0, 0, 0, 0, 36'd777 << 12);
    checks++; if (a_st(1, 0) !== 3'd2 || a_st(1, 1) !== 3'd1) begin errors++; $display("FAIL mid_setup: got b0 %0d b1 %0d exp 2 1", a_st(1, 0), a_st(1, 1)); end
    do_reset();
    checks++; if (a_st(1, 0) !== 3'd0 || a_st(1, 1) !== 3'd0 || a_dp(1, 1) !== 12'd0 || a_sin(1) !== 2'd0 || a_rdy(1) !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got b0 %0d b1 %0d dp1 %0d sel_in %0d rdy %b exp 0 0 0 0 1", a_st(1, 0), a_st(1, 1), a_dp(1, 1), a_sin(1), a_rdy(1)); end
    step(1, 3'b001, 0, 0, 0, 0, 36'd5);
    checks++; if (a_st(1, 0) !== 3'd1 || a_dp(1, 0) !== 12'd5 || a_err(1) !== 1'b0) begin
      errors++; $display("FAIL mid_accept: got state %0d dftpts %0d err %b exp 1 5 0", a_st(1, 0), a_dp(1, 0), a_err(1)); end
  endtask

  task automatic test_random(input int d, input int n, input bit legal);
    int nb;
    logic [2:0] sop, eop, cd, ss, se;
    logic [35:0] pts;
    nb = d ? 3 : 2;
    for (int i = 0; i < n; i++) begin
      sop = '0; eop = '0; cd = '0; ss = '0; se = '0; pts = '0;
      for (int b = 0; b < nb; b++) begin
        pts[b*12 +: 12] = 12'($urandom_range(0, 4095));
        if (legal) begin
          case (st_m[d][b])
            IDLE: if (b == sel_in_m[d] && $urandom_range(0, 2) == 0) begin sop[b] = 1'b1; eop[b] = ($urandom_range(0, 3) == 0); end
            SINK: eop[b] = ($urandom_range(0, 3) == 0);
            CALC: cd[b]  = ($urandom_range(0, 2) == 0);
            WAIT: ss[b]  = (b == sel_out_m[d]) && ($urandom_range(0, 1) == 0);
            SRC:  se[b]  = ($urandom_range(0, 2) == 0);
            default: ;
          endcase
        end else begin
          sop[b] = ($urandom_range(0, 5) == 0); eop[b] = ($urandom_range(0, 5) == 0);
          cd[b]  = ($urandom_range(0, 5) == 0); ss[b]  = ($urandom_range(0, 5) == 0);
          se[b]  = ($urandom_range(0, 5) == 0);
        end
      end
      step(d, sop, eop, cd, ss, se, pts);
      checks++; if (a_sin(d) !== 2'(sel_in_m[d]))   begin errors++; $display("FAIL rnd_sel_in d%0d cyc%0d: got %0d exp %0d", d, i, a_sin(d), sel_in_m[d]); end
      checks++; if (a_sout(d) !== 2'(sel_out_m[d])) begin errors++; $display("FAIL rnd_sel_out d%0d cyc%0d: got %0d exp %0d", d, i, a_sout(d), sel_out_m[d]); end
      checks++; if (a_rdy(d) !== (st_m[d][sel_in_m[d]] == IDLE)) begin errors++; $display("FAIL rnd_ready d%0d cyc%0d: got %b", d, i, a_rdy(d)); end
      checks++; if (a_err(d) !== err_m[d]) begin errors++; $display("FAIL rnd_err d%0d cyc%0d: got %b exp %b", d, i, a_err(d), err_m[d]); end
      checks++; if (a_cs(d) !== cs_m[d])   begin errors++; $display("FAIL rnd_calc_start d%0d cyc%0d: got %b exp %b", d, i, a_cs(d), cs_m[d]); end
      for (int b = 0; b < nb; b++) begin
        checks++; if (a_st(d, b) !== 3'(st_m[d][b])) begin errors++; $display("FAIL rnd_state d%0d b%0d cyc%0d: got %0d exp %0d", d, b, i, a_st(d, b), st_m[d][b]); end
        checks++; if (a_dp(d, b) !== pts_m[d][b])    begin errors++; $display("FAIL rnd_dftpts d%0d b%0d cyc%0d: got %0d exp %0d", d, b, i, a_dp(d, b), pts_m[d][b]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_one_packet();
    test_full();
    test_out_of_order();
    test_simultaneous();
    test_one_sample();
    test_reset_mid();
    for (int d = 0; d < 2; d++) begin
      do_reset();
      test_random(d, 600, 1'b1);
      do_reset();
      test_random(d, 150, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
